// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule tables, types and C/D rotation helper.
package des_pkg;
  typedef logic [0:63] des_key_t;
  typedef logic [0:27] des_cd_t;
  typedef logic [0:47] des_subkey_t;
  typedef enum logic {IDLE, GEN} ks_state_t;
  // Table entries are 0-based bit indices (DES bit n -> n-1).
  localparam logic [5:0] PC1_TABLE [0:55] = '{
    6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,
    6'd0,  6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17,
    6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26,
    6'd18, 6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35,
    6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14,
    6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21,
    6'd13, 6'd5,  6'd60, 6'd52, 6'd44, 6'd36, 6'd28,
    6'd20, 6'd12, 6'd4,  6'd27, 6'd19, 6'd11, 6'd3};
  localparam logic [5:0] PC2_TABLE [0:47] = '{
    6'd13, 6'd16, 6'd10, 6'd23, 6'd0,  6'd4,
    6'd2,  6'd27, 6'd14, 6'd5,  6'd20, 6'd9,
    6'd22, 6'd18, 6'd11, 6'd3,  6'd25, 6'd7,
    6'd15, 6'd6,  6'd26, 6'd19, 6'd12, 6'd1,
    6'd40, 6'd51, 6'd30, 6'd36, 6'd46, 6'd54,
    6'd29, 6'd39, 6'd50, 6'd44, 6'd32, 6'd47,
    6'd43, 6'd48, 6'd38, 6'd55, 6'd33, 6'd52,
    6'd45, 6'd41, 6'd49, 6'd35, 6'd28, 6'd31};
  localparam logic [1:0] SHIFT_SCHED [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  function automatic des_cd_t rot_cd(input des_cd_t x, input logic [1:0] n, input logic right);
    return right ? (n == 2'd2 ? {x[26:27], x[0:25]} : n == 2'd1 ? {x[27], x[0:26]} : x)
                 : (n == 2'd2 ? {x[2:27], x[0:1]} : n == 2'd1 ? {x[1:27], x[0]} : x);
  endfunction
endpackage

// File: rtl/des_pc1_permute.sv
// des_pc1_permute: combinational PC-1 selection, 64-bit key to 56-bit C||D.
module des_pc1_permute
  import des_pkg::*;
(
  input  des_key_t    key,
  output logic [0:55] cd
);
  always_comb
    for (int i = 0; i < 56; i++) cd[i] = key[PC1_TABLE[i]];
endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES/3DES round-key generator with valid/ready handshakes.
// Optional DES_KEY_PARITY_CHECK_EN adds a registered odd-parity error flag on accepted keys.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_KEYS = 3
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [0:64*NUM_KEYS-1]  key_in,
  input  logic                    mode,
  input  logic                    flush,
  output logic                    subkey_valid,
  input  logic                    subkey_ready,
  output des_subkey_t             subkey,
  output logic [3:0]              round_idx,
  output logic [1:0]              pass_idx,
  output logic                    last,
  output logic                    busy
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic                    parity_err
`endif
);
  localparam logic [1:0] LAST_PASS = (NUM_KEYS == 1) ? 2'd0 : 2'd2;
  if (NUM_KEYS < 1 || NUM_KEYS > 3) begin : g_bad_num_keys
    $error("des_key_schedule: NUM_KEYS must be 1..3");
  end
  ks_state_t state_q, state_d;
  logic [0:64*NUM_KEYS-1] keys_q, keys_d;
  logic mode_q, mode_d;
  des_cd_t c_q, c_d, d_q, d_d;
  logic [3:0] round_q, round_d;
  logic [1:0] pass_q, pass_d, sh;
  des_key_t kin [0:2];
  des_key_t kreg [0:2];
  des_key_t pass_key;
  logic [0:55] pc1_cd, cd;
  logic gen, hs, accept, load_dec, cur_dec;
  // Logical K1..K3 map onto physical slots modulo NUM_KEYS (K3 = K1 when NUM_KEYS = 2).
  always_comb
    for (int i = 0; i < 3; i++) begin
      kin[i] = key_in[64*(i%NUM_KEYS) +: 64];
      kreg[i] = keys_q[64*(i%NUM_KEYS) +: 64];
    end
  assign gen = state_q == GEN;
  assign pass_key = gen ? kreg[pass_q == 2'd0 ? 2'd1 : (mode_q ? 2'd0 : 2'd2)] : kin[mode ? 2'd2 : 2'd0];
  assign load_dec = gen ? (pass_q == 2'd0 ? !mode_q : mode_q) : mode;
  assign cur_dec = mode_q ^ (pass_q == 2'd1);
  assign sh = cur_dec ? SHIFT_SCHED[4'd15 - round_q] : SHIFT_SCHED[round_q + 4'd1];
  assign hs = gen && subkey_ready;
  assign accept = !gen && key_valid && !flush;
  des_pc1_permute u_pc1 (.key(pass_key), .cd(pc1_cd));
  always_comb begin
    state_d = state_q;
    keys_d = keys_q;
    mode_d = mode_q;
    c_d = c_q;
    d_d = d_q;
    round_d = round_q;
    pass_d = pass_q;
    if (flush) begin
      state_d = IDLE;
      round_d = '0;
      pass_d = '0;
    end else if (accept || (hs && !last && round_q == 4'd15)) begin
      state_d = GEN;
      keys_d = accept ? key_in : keys_q;
      mode_d = accept ? mode : mode_q;
      pass_d = accept ? 2'd0 : pass_q + 2'd1;
      c_d = rot_cd(pc1_cd[0:27], load_dec ? 2'd0 : 2'd1, 1'b0);
      d_d = rot_cd(pc1_cd[28:55], load_dec ? 2'd0 : 2'd1, 1'b0);
      round_d = '0;
    end else if (hs && last) begin
      state_d = IDLE;
      round_d = '0;
      pass_d = '0;
    end else if (hs) begin
      c_d = rot_cd(c_q, sh, cur_dec);
      d_d = rot_cd(d_q, sh, cur_dec);
      round_d = round_q + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= IDLE;
      keys_q <= '0;
      mode_q <= 1'b0;
      c_q <= '0;
      d_q <= '0;
      round_q <= '0;
      pass_q <= '0;
    end else begin
      state_q <= state_d;
      keys_q <= keys_d;
      mode_q <= mode_d;
      c_q <= c_d;
      d_q <= d_d;
      round_q <= round_d;
      pass_q <= pass_d;
    end
  assign cd = {c_q, d_q};
  always_comb
    for (int i = 0; i < 48; i++) subkey[i] = cd[PC2_TABLE[i]];
  assign key_ready = !gen;
  assign subkey_valid = gen;
  assign busy = gen;
  assign round_idx = round_q;
  assign pass_idx = pass_q;
  assign last = gen && round_q == 4'd15 && pass_q == LAST_PASS;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;
  always_comb begin
    parity_err_d = flush ? 1'b0 : parity_err_q;
    if (accept) begin
      parity_err_d = 1'b0;
      for (int i = 0; i < 8*NUM_KEYS; i++) parity_err_d = parity_err_d | ~^key_in[8*i +: 8];
    end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) parity_err_q <= 1'b0;
    else parity_err_q <= parity_err_d;
  assign parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: directed + randomized checks of NUM_KEYS=3 and NUM_KEYS=1 instances against a cumulative-shift DES key model.
module tb_des_key_schedule;
  localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                              63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                              41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [63:0] KV = 64'h133457799BBCDFF1;

  logic clk = 0, n_rst = 0;
  always #5 clk = ~clk;
  logic kv3 = 0, kv1 = 0, mode = 0, flush = 0, sr = 0;
  logic [0:191] kin3 = '0;
  logic [0:63] kin1 = '0;
  logic kr3, sv3, last3, busy3, kr1, sv1, last1, busy1;
  logic [0:47] sk3, sk1;
  logic [3:0] ri3, ri1;
  logic [1:0] pi3, pi1;
  logic pe3, pe1;
  int sel = 3, checks = 0, failures = 0;
  logic o_kr, o_sv, o_last, o_busy, o_pe;
  logic [47:0] o_sk;
  logic [3:0] o_ri;
  logic [1:0] o_pi;

  des_key_schedule #(.NUM_KEYS(3)) u3 (.clk(clk), .n_rst(n_rst), .key_valid(kv3), .key_ready(kr3), .key_in(kin3),
    .mode(mode), .flush(flush), .subkey_valid(sv3), .subkey_ready(sr), .subkey(sk3), .round_idx(ri3),
    .pass_idx(pi3), .last(last3), .busy(busy3)
`ifdef DES_KEY_PARITY_CHECK_EN
    , .parity_err(pe3)
`endif
  );
  des_key_schedule #(.NUM_KEYS(1)) u1 (.clk(clk), .n_rst(n_rst), .key_valid(kv1), .key_ready(kr1), .key_in(kin1),
    .mode(mode), .flush(flush), .subkey_valid(sv1), .subkey_ready(sr), .subkey(sk1), .round_idx(ri1),
    .pass_idx(pi1), .last(last1), .busy(busy1)
`ifdef DES_KEY_PARITY_CHECK_EN
    , .parity_err(pe1)
`endif
  );
`ifndef DES_KEY_PARITY_CHECK_EN
  assign pe3 = 1'b0;
  assign pe1 = 1'b0;
`endif

  always_comb begin
    o_kr = sel == 3 ? kr3 : kr1;
    o_sv = sel == 3 ? sv3 : sv1;
    o_sk = sel == 3 ? sk3 : sk1;
    o_ri = sel == 3 ? ri3 : ri1;
    o_pi = sel == 3 ? pi3 : pi1;
    o_last = sel == 3 ? last3 : last1;
    o_busy = sel == 3 ? busy3 : busy1;
    o_pe = sel == 3 ? pe3 : pe1;
  end

  function automatic logic [47:0] subkey_of(input logic [63:0] k, input int r);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] o;
    int s;
    s = 0;
    for (int j = 1; j <= 56; j++) cd[56-j] = k[64-PC1[j-1]];
    for (int i = 0; i <= r; i++) s += SH[i];
    c = cd[55:28];
    d = cd[27:0];
    c = (c << s) | (c >> (28 - s));
    d = (d << s) | (d >> (28 - s));
    cd = {c, d};
    for (int j = 1; j <= 48; j++) o[48-j] = cd[56-PC2[j-1]];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic m);
    int t;
    t = 0;
    while (o_kr !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("key_ready_before_accept", o_kr, 1);
    mode = m;
    kin3 = {a, b, c};
    kin1 = a;
    if (sel == 3) kv3 = 1; else kv1 = 1;
    @(negedge clk);
    kv3 = 0;
    kv1 = 0;
    chk("valid_after_accept", o_sv, 1);
    chk("key_ready_busy", o_kr, 0);
    chk("busy", o_busy, 1);
  endtask

  task automatic run_job(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic m,
                         input bit bp, input int flush_at, input bit poke,
                         output logic [47:0] first, output logic [47:0] lastk);
    logic [47:0] exp[$];
    logic [63:0] keys [3];
    logic [63:0] kk;
    int np, idx, cyc, stall;
    bit dec, r;
    keys = '{a, b, c};
    np = sel == 3 ? 3 : 1;
    for (int p = 0; p < np; p++) begin
      kk = np == 1 ? a : keys[m ? 2 - p : p];
      dec = m ^ (p == 1);
      for (int q = 0; q < 16; q++) exp.push_back(subkey_of(kk, dec ? 15 - q : q));
    end
    first = 'x;
    lastk = 'x;
    accept(a, b, c, m);
    idx = 0; cyc = 0; stall = 0;
    while (idx < exp.size() && cyc < 1000) begin
      chk("valid_no_bubble", o_sv, 1);
      chk("subkey", o_sk, exp[idx]);
      chk("round_idx", o_ri, idx % 16);
      chk("pass_idx", o_pi, idx / 16);
      chk("last", o_last, idx == exp.size() - 1);
      if (idx == 0) first = o_sk;
      lastk = o_sk;
      if (idx == flush_at) begin
        flush = 1;
        sr = 1'($urandom);
        @(negedge clk);
        flush = 0;
        chk("flush_valid_low", o_sv, 0);
        chk("flush_key_ready", o_kr, 1);
        return;
      end
      if (bp && idx == 7 && stall < 3) begin r = 0; stall++; end
      else r = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (poke && idx == 20) begin kin3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}; kin1 = kin3[0:63]; kv3 = 1; kv1 = 1; end
      sr = r;
      @(negedge clk);
      kv3 = 0;
      kv1 = 0;
      cyc++;
      if (r) idx++;
    end
    chk("job_completed", idx, exp.size());
    sr = 0;
    chk("done_valid_low", o_sv, 0);
    chk("done_key_ready", o_kr, 1);
    chk("done_busy", o_busy, 0);
    chk("done_last", o_last, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [47:0] f, l;
    logic [63:0] ra, rb, rc;
    @(negedge clk);
    for (int s = 1; s <= 3; s += 2) begin
      sel = s;
      #0;
      chk("rst_key_ready", o_kr, 1);
      chk("rst_valid", o_sv, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_last", o_last, 0);
      chk("rst_round", o_ri, 0);
      chk("rst_pass", o_pi, 0);
      chk("rst_subkey", o_sk, 0);
      chk("rst_parity", o_pe, 0);
    end
    n_rst = 1;
    @(negedge clk);
    sel = 1;
    run_job(KV, 0, 0, 0, 0, -1, 0, f, l);
    chk("des_enc_first", f, 48'h1B02EFFC7072);
    chk("des_enc_round15", l, 48'hCB3D8B0E17F5);
    run_job(KV, 0, 0, 1, 0, -1, 0, f, l);
    chk("des_dec_first", f, 48'hCB3D8B0E17F5);
    chk("des_dec_round15", l, 48'h1B02EFFC7072);
    run_job({$urandom, $urandom}, 0, 0, 1, 1, -1, 1, f, l);
    sel = 3;
    run_job(KV, 0, 0, 0, 0, -1, 0, f, l);
    chk("tdes_first", f, 48'h1B02EFFC7072);
    for (int j = 0; j < 2; j++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = {$urandom, $urandom};
      run_job(ra, rb, rc, 1'(j), 1, -1, 1, f, l);
    end
    run_job({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1, 20, 0, f, l);
    run_job({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1, 0, -1, 0, f, l);
    kv3 = 1; flush = 1; kin3 = {KV, KV, KV};
    @(negedge clk);
    kv3 = 0; flush = 0;
    chk("flush_beats_key_valid", o_sv, 0);
    chk("flush_beats_key_ready", o_kr, 1);
    accept(KV, 64'h0123456789ABCDEF, KV, 0);
    sr = 1;
    repeat (5) @(negedge clk);
    #2 n_rst = 0;
    #1;
    chk("async_rst_valid", o_sv, 0);
    chk("async_rst_key_ready", o_kr, 1);
    chk("async_rst_round", o_ri, 0);
    chk("async_rst_subkey", o_sk, 0);
    chk("async_rst_busy", o_busy, 0);
    @(negedge clk);
    n_rst = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", o_sv, 0);
    end
    sr = 0;
    run_job(KV, 0, 0, 0, 0, -1, 0, f, l);
    chk("post_rst_first", f, 48'h1B02EFFC7072);
`ifdef DES_KEY_PARITY_CHECK_EN
    sel = 1;
    accept(64'h133457799BBCDFF0, 0, 0, 0);
    chk("parity_bad", o_pe, 1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("parity_clr_flush", o_pe, 0);
    accept(KV, 0, 0, 0);
    chk("parity_good", o_pe, 0);
    flush = 1;
    @(negedge clk);
    flush = 0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES/3DES round-key generator. Accepts a bundle of up to three 64-bit keys and emits 48-bit round subkeys one per handshake, in cipher order.
- Applies PC-1, per-round C/D rotation (left for encrypt, right for decrypt) and PC-2.
- Sits between the key-exchange/derivation logic and the DES round datapath.
- Generalises a fixed single PC-2 stage to a full schedule with multi-key, mode and backpressure support.

Parameters:
- NUM_KEYS, 3, key slots used: 1 = single DES; 2 = 3DES keying option 2 (K3 = K1); 3 = 3DES keying option 1. Values outside 1..3 are illegal and stop elaboration.

Ports:
- clk  input  1  clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- key_valid  input  1  key bundle offered
- key_ready  output  1  block can accept a bundle
- key_in  input  [0:64*NUM_KEYS-1]  slot 0 at bits [0:63]; DES bit 1 = index 0; parity bits ignored
- mode  input  1  0 = encrypt (EDE), 1 = decrypt (DED); sampled with the key
- flush  input  1  synchronous abort to IDLE
- subkey_valid  output  1  subkey presented
- subkey_ready  input  1  consumer takes subkey
- subkey  output  [0:47]  current round key
- round_idx  output  4  0..15 within the current pass
- pass_idx  output  2  0..2, DES pass number
- last  output  1  final subkey of the job
- busy  output  1  job in progress

Behaviour:
- Reset: key_ready=1; subkey_valid=0; busy=0; last=0; round_idx=0; pass_idx=0; subkey=0; all C/D and key registers cleared.
- States:
  - IDLE: key_ready=1.
  - GEN: key_ready=0.
- IDLE->GEN on key_valid&&key_ready.
  - Latch key_in and mode.
  - Load C/D from PC-1 of the first pass key, with that pass's initial rotation applied.
  - subkey_valid=1 in the next cycle. Latency is 1 cycle from the accept edge.
- Pass order:
  - Encrypt: (K1,enc), (K2,dec), (K3,enc).
  - Decrypt: (K3,dec), (K2,enc), (K1,dec).
  - NUM_KEYS=1: single pass, K1 with mode.
  - NUM_KEYS=2: K3 = K1.
  - Passes per job: 1 if NUM_KEYS=1, otherwise 3.
- Shift table SH[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Enc pass, round r: C/D rotated left by SH[r] before PC-2.
  - Dec pass, round r: rotated right by 0 for r=0, by SH[16-r] for r>=1.
- subkey = PC-2(C||D), computed from registered C/D. subkey, round_idx, pass_idx and last are stable while subkey_valid && !subkey_ready.
- On a handshake with round_idx<15: rotate C/D, round_idx++.
- On a handshake at round_idx=15 of a non-final pass:
  - Reload C/D from the next pass key with its initial rotation.
  - round_idx=0, pass_idx++.
  - No bubble between passes.
- On a handshake with last=1: GEN->IDLE, subkey_valid=0. key_ready rises the next cycle, so there is one idle cycle between jobs.
- last=1 exactly when round_idx=15 and the pass is final.
- busy=1 in GEN.
- key_valid while busy: ignored and not stored.
- flush: highest synchronous priority. Next cycle is IDLE with subkey_valid=0; the in-flight job is discarded. Flush in IDLE is a no-op.
- flush and key_valid in the same IDLE cycle: flush wins and the key is not accepted.
- n_rst assertion mid-job: immediate return to reset values; no subkey is delivered after release until a new key is accepted.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN.
- Enabled:
  - Adds output parity_err (1 bit, reset 0).
  - On accept, each key byte is checked for odd parity.
  - parity_err is registered high in the cycle after accept if any byte fails. It holds until the next accept, flush or reset.
  - The schedule still runs; parity_err is informational.
- Disabled: no port, no logic.

Decomposition:
- Package des_pkg holds:
  - PC1_TABLE (56 x 6-bit) and PC2_TABLE (48 x 6-bit) constants.
  - SHIFT_SCHED (16 x 2-bit).
  - typedef des_key_t [0:63], des_cd_t [0:27], des_subkey_t [0:47].
  - enum ks_state_t {IDLE, GEN}.
- Sub-module des_pc1_permute: combinational 64->56 bit permutation driven from PC1_TABLE, one instance, fed by a pass-key mux.
- PC-2 and rotation stay in the top as package-table loops.

Test Plan:
- NUM_KEYS=1, mode=0, key 133457799BBCDFF1, subkey_ready=1 -> subkey_valid one cycle after accept; 16 consecutive subkeys; first 1B02EFFC7072, round 15 CB3D8B0E17F5 with last=1; key_ready back high after 1 idle cycle.
- Same key, mode=1 -> first subkey CB3D8B0E17F5, round 15 1B02EFFC7072; the sequence is the exact reverse of the encrypt run.
- NUM_KEYS=3, K1=133457799BBCDFF1, K2=K3=0 -> 48 subkeys:
  - pass 0 matches the encrypt vector;
  - pass 1 is all-zero subkeys in decrypt order;
  - pass_idx steps 0,1,2 with no bubble;
  - last only on the 48th subkey.
- Backpressure: subkey_ready toggles randomly (0 for 3 cycles at round 7) -> subkey and indices are held stable; no round skipped or repeated; key_valid pulsed mid-job is ignored.
- flush at pass 1 round 4 -> next cycle subkey_valid=0 and key_ready=1; a new job starts cleanly from round 0 with correct values.
- n_rst pulsed mid-job -> outputs immediately at reset values; with DES_KEY_PARITY_CHECK_EN, key 133457799BBCDFF0 -> parity_err=1; key 133457799BBCDFF1 -> parity_err=0.
